// File: rtl/cred_ram_auth_if.sv
// Request/response bundle between the login controller and the credential store.
interface cred_ram_auth_if #(
  parameter int ADDR_W = 12,
  parameter int PASS_W = 16,
  parameter int CNT_W  = 4
);
  logic              my_cs;
  logic              my_pass_rw;
  logic              my_count_rw;
  logic              my_admin_rw;
  logic              my_lock_rw;
  logic [ADDR_W-1:0] my_addr;
  logic [PASS_W-1:0] my_pass_in;
  logic [CNT_W-1:0]  my_count_in;
  logic              my_admin_in;
  logic              my_lock_in;
  logic              my_auth_start;
  logic [PASS_W-1:0] my_pass_out;
  logic [CNT_W-1:0]  my_count_out;
  logic              my_admin_out;
  logic              my_lock_out;
  logic              my_ready;
  logic              my_auth_done;
  logic              my_auth_ok;
  logic              my_auth_locked;

  modport master (
    output my_cs, my_pass_rw, my_count_rw, my_admin_rw, my_lock_rw, my_addr,
           my_pass_in, my_count_in, my_admin_in, my_lock_in, my_auth_start,
    input  my_pass_out, my_count_out, my_admin_out, my_lock_out, my_ready,
           my_auth_done, my_auth_ok, my_auth_locked
  );

  modport slave (
    input  my_cs, my_pass_rw, my_count_rw, my_admin_rw, my_lock_rw, my_addr,
           my_pass_in, my_count_in, my_admin_in, my_lock_in, my_auth_start,
    output my_pass_out, my_count_out, my_admin_out, my_lock_out, my_ready,
           my_auth_done, my_auth_ok, my_auth_locked
  );
endinterface

// File: rtl/cred_ram_auth.sv
// Credential store with post-reset scrub and an in-place authentication engine
// (read, compare, write back try count / lock flag).
module cred_ram_auth #(
  parameter int ADDR_W    = 12,
  parameter int PASS_W    = 16,
  parameter int CNT_W     = 4,
  parameter int MAX_TRIES = 3
) (
  input logic            my_clk,
  input logic            my_rst,
  cred_ram_auth_if.slave bus
);
  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_TRIES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {SCRUB, IDLE, RD, CMP, WB} state_t;

  state_t state, state_nxt;

  logic [PASS_W-1:0] pass_mem  [DEPTH];
  logic [CNT_W-1:0]  count_mem [DEPTH];
  logic              admin_mem [DEPTH];
  logic              lock_mem  [DEPTH];

  logic [ADDR_W-1:0] scrub_addr, auth_addr;
  logic [PASS_W-1:0] auth_pass, rec_pass;
  logic [CNT_W-1:0]  rec_cnt, cmp_cnt, wb_cnt;
  logic              rec_admin, rec_lock;
  logic              cmp_lock, cmp_we, cmp_ok, cmp_locked;
  logic              wb_lock, wb_en, res_ok, res_locked;
  logic [PASS_W-1:0] pass_q;
  logic [CNT_W-1:0]  count_q;
  logic              admin_q, lock_q, done_q, ok_q, locked_q;
  logic              dir_acc, auth_acc, scrub_we, wb_we;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c >= MAX_C) return MAX_C;
    return c + CNT_W'(1);
  endfunction

  assign dir_acc  = (state == IDLE) && bus.my_cs && !bus.my_auth_start && !my_rst;
  assign auth_acc = (state == IDLE) && bus.my_cs && bus.my_auth_start && !my_rst;
  assign scrub_we = (state == SCRUB) && !my_rst;
  assign wb_we    = (state == WB) && wb_en && !my_rst;

  always_ff @(posedge my_clk) begin
    if (my_rst) state <= SCRUB;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCRUB:   if (scrub_addr == LAST_ADDR) state_nxt = IDLE;
      IDLE:    if (auth_acc) state_nxt = RD;
      RD:      state_nxt = CMP;
      CMP:     state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = SCRUB;
    endcase
  end

  // Storage: scrub, direct field writes and auth writeback never share a cycle.
  always_ff @(posedge my_clk) begin
    if (scrub_we) begin
      pass_mem[scrub_addr]  <= '0;
      count_mem[scrub_addr] <= '0;
      admin_mem[scrub_addr] <= 1'b0;
      lock_mem[scrub_addr]  <= 1'b0;
    end
    if (dir_acc) begin
      if (bus.my_pass_rw)  pass_mem[bus.my_addr]  <= bus.my_pass_in;
      if (bus.my_count_rw) count_mem[bus.my_addr] <= bus.my_count_in;
      if (bus.my_admin_rw) admin_mem[bus.my_addr] <= bus.my_admin_in;
      if (bus.my_lock_rw)  lock_mem[bus.my_addr]  <= bus.my_lock_in;
    end
    if (wb_we) begin
      count_mem[auth_addr] <= wb_cnt;
      lock_mem[auth_addr]  <= wb_lock;
    end
  end

  // Stage p0: latch request; RD: fetch record
  always_ff @(posedge my_clk) begin
    if (auth_acc) begin
      auth_addr <= bus.my_addr;
      auth_pass <= bus.my_pass_in;
    end
    if (state == RD) begin
      rec_pass  <= pass_mem[auth_addr];
      rec_cnt   <= count_mem[auth_addr];
      rec_admin <= admin_mem[auth_addr];
      rec_lock  <= lock_mem[auth_addr];
    end
    if (state == CMP) begin
      wb_cnt     <= cmp_cnt;
      wb_lock    <= cmp_lock;
      wb_en      <= cmp_we;
      res_ok     <= cmp_ok;
      res_locked <= cmp_locked;
    end
  end

  // CMP: decide outcome from the fetched record, lock has priority over match
  always_comb begin
    cmp_ok     = 1'b0;
    cmp_locked = 1'b0;
    cmp_we     = 1'b0;
    cmp_cnt    = rec_cnt;
    cmp_lock   = rec_lock;
    if (rec_lock) begin
      cmp_locked = 1'b1;
    end else if (auth_pass == rec_pass) begin
      cmp_ok  = 1'b1;
      cmp_we  = 1'b1;
      cmp_cnt = '0;
    end else begin
      cmp_we  = 1'b1;
      cmp_cnt = sat_inc(rec_cnt);
      if (!rec_admin && (cmp_cnt == MAX_C)) begin
        cmp_lock   = 1'b1;
        cmp_locked = 1'b1;
      end
    end
  end

  // WB and direct reads: registered outputs and result flags
  always_ff @(posedge my_clk) begin
    if (my_rst) begin
      scrub_addr <= '0;
      pass_q     <= '0;
      count_q    <= '0;
      admin_q    <= 1'b0;
      lock_q     <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == SCRUB) scrub_addr <= scrub_addr + ADDR_W'(1);
      if (dir_acc) begin
        pass_q  <= pass_mem[bus.my_addr];
        count_q <= count_mem[bus.my_addr];
        admin_q <= admin_mem[bus.my_addr];
        lock_q  <= lock_mem[bus.my_addr];
      end
      if (state == WB) begin
        done_q   <= 1'b1;
        ok_q     <= res_ok;
        locked_q <= res_locked;
        pass_q   <= rec_pass;
        count_q  <= wb_cnt;
        admin_q  <= rec_admin;
        lock_q   <= wb_lock;
      end
    end
  end

  assign bus.my_pass_out    = pass_q;
  assign bus.my_count_out   = count_q;
  assign bus.my_admin_out   = admin_q;
  assign bus.my_lock_out    = lock_q;
  assign bus.my_ready       = (state == IDLE);
  assign bus.my_auth_done   = done_q;
  assign bus.my_auth_ok     = ok_q;
  assign bus.my_auth_locked = locked_q;
endmodule

// File: tb/tb_cred_ram_auth.sv
// Directed bench for cred_ram_auth: record-level model plus per-cycle output compare.
module tb_cred_ram_auth;
  localparam int AW = 4, PW = 16, CW = 4, MT = 3, DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0, n_fail = 0, n_done = 0;
  bit   chk = 1'b0;

  logic          exp_ready, exp_done, exp_ok, exp_locked, exp_admin, exp_lock;
  logic [PW-1:0] exp_pass;
  logic [CW-1:0] exp_cnt;

  logic [PW-1:0] m_pass  [DEPTH];
  logic [CW-1:0] m_cnt   [DEPTH];
  logic          m_admin [DEPTH];
  logic          m_lock  [DEPTH];

  cred_ram_auth_if #(.ADDR_W(AW), .PASS_W(PW), .CNT_W(CW)) bus();

  cred_ram_auth #(.ADDR_W(AW), .PASS_W(PW), .CNT_W(CW), .MAX_TRIES(MT)) dut (
    .my_clk(clk),
    .my_rst(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check("ready",   32'(bus.my_ready),       32'(exp_ready));
      check("done",    32'(bus.my_auth_done),   32'(exp_done));
      check("ok",      32'(bus.my_auth_ok),     32'(exp_ok));
      check("locked",  32'(bus.my_auth_locked), 32'(exp_locked));
      check("pass",    32'(bus.my_pass_out),    32'(exp_pass));
      check("count",   32'(bus.my_count_out),   32'(exp_cnt));
      check("admin",   32'(bus.my_admin_out),   32'(exp_admin));
      check("lockout", 32'(bus.my_lock_out),    32'(exp_lock));
      if (bus.my_auth_done) n_done++;
    end
  end

  task automatic idle_inputs();
    bus.my_cs = 1'b0;         bus.my_auth_start = 1'b0;
    bus.my_pass_rw = 1'b0;    bus.my_count_rw = 1'b0;
    bus.my_admin_rw = 1'b0;   bus.my_lock_rw = 1'b0;
    bus.my_addr = '0;         bus.my_pass_in = '0;
    bus.my_count_in = '0;     bus.my_admin_in = 1'b0;
    bus.my_lock_in = 1'b0;
  endtask

  task automatic load_exp(input logic [AW-1:0] a);
    exp_pass = m_pass[a]; exp_cnt = m_cnt[a];
    exp_admin = m_admin[a]; exp_lock = m_lock[a];
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk = 1'b1;
    exp_ready = 0; exp_done = 0; exp_ok = 0; exp_locked = 0;
    exp_pass = '0; exp_cnt = '0; exp_admin = 0; exp_lock = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_pass[i] = '0; m_cnt[i] = '0; m_admin[i] = 0; m_lock[i] = 0;
    end
    for (int i = 1; i <= DEPTH; i++) begin
      @(posedge clk); #1;
      if (i == DEPTH) exp_ready = 1'b1;
    end
  endtask

  task automatic direct(input logic [AW-1:0] a, input bit pw, cw, aw, lw,
                        input logic [PW-1:0] p, input logic [CW-1:0] c, input bit ad, lk);
    bus.my_cs = 1'b1; bus.my_auth_start = 1'b0; bus.my_addr = a;
    bus.my_pass_rw = pw; bus.my_count_rw = cw; bus.my_admin_rw = aw; bus.my_lock_rw = lw;
    bus.my_pass_in = p; bus.my_count_in = c; bus.my_admin_in = ad; bus.my_lock_in = lk;
    @(posedge clk); #1;
    exp_done = 1'b0;
    load_exp(a);
    if (pw) m_pass[a] = p;
    if (cw) m_cnt[a] = c;
    if (aw) m_admin[a] = ad;
    if (lw) m_lock[a] = lk;
    idle_inputs();
  endtask

  task automatic rd(input logic [AW-1:0] a);
    direct(a, 0, 0, 0, 0, '0, '0, 0, 0);
  endtask

  // Returns in the done cycle; poke keeps hammering requests while busy.
  task automatic auth(input logic [AW-1:0] a, input logic [PW-1:0] p, input bit poke);
    bit r_ok, r_lk;
    int c;
    bus.my_cs = 1'b1; bus.my_auth_start = 1'b1; bus.my_addr = a; bus.my_pass_in = p;
    bus.my_pass_rw = 1'b1; bus.my_count_rw = 1'b1; bus.my_admin_rw = 1'b1; bus.my_lock_rw = 1'b1;
    bus.my_count_in = 4'hF; bus.my_admin_in = 1'b1; bus.my_lock_in = 1'b1;
    @(posedge clk); #1;
    exp_ready = 1'b0; exp_done = 1'b0;
    r_ok = 0; r_lk = 0;
    if (m_lock[a]) begin
      r_lk = 1;
    end else if (p == m_pass[a]) begin
      r_ok = 1; m_cnt[a] = '0;
    end else begin
      c = int'(m_cnt[a]) + 1;
      if (c > MT) c = MT;
      m_cnt[a] = CW'(c);
      if (!m_admin[a] && c == MT) begin r_lk = 1; m_lock[a] = 1'b1; end
    end
    for (int k = 0; k < 3; k++) begin
      if (poke) begin
        bus.my_cs = 1'b1; bus.my_auth_start = 1'b1; bus.my_addr = a;
        bus.my_pass_rw = 1'b1; bus.my_pass_in = 16'hDEAD;
      end else idle_inputs();
      @(posedge clk); #1;
    end
    idle_inputs();
    exp_ready = 1'b1; exp_done = 1'b1; exp_ok = r_ok; exp_locked = r_lk;
    load_exp(a);
  endtask

  initial begin
    int d0;
    int cseq [5] = '{1, 2, 3, 3, 3};
    idle_inputs();
    do_reset();
    rd(4'd0);  rd(4'd7);  rd(4'd15);
    check("rst_pass15", 32'(bus.my_pass_out), 32'h0);
    check("rst_cnt15",  32'(bus.my_count_out), 32'h0);

    direct(4'd5, 1, 0, 1, 1, 16'h1234, 4'd7, 1, 0);
    rd(4'd5);
    check("wr5_pass",  32'(bus.my_pass_out),  32'h1234);
    check("wr5_cnt",   32'(bus.my_count_out), 32'h0);
    check("wr5_admin", 32'(bus.my_admin_out), 32'h1);
    direct(4'd5, 1, 0, 0, 0, 16'hBEEF, 4'd9, 0, 1);
    rd(4'd5);
    check("part_pass", 32'(bus.my_pass_out), 32'hBEEF);
    check("part_lock", 32'(bus.my_lock_out), 32'h0);
    direct(4'd5, 1, 1, 0, 0, 16'h1234, 4'd2, 0, 0);
    auth(4'd5, 16'h1234, 0);
    check("a5_ok",  32'(bus.my_auth_ok), 32'h1);
    check("a5_lk",  32'(bus.my_auth_locked), 32'h0);
    rd(4'd5);
    check("a5_cnt", 32'(bus.my_count_out), 32'h0);

    direct(4'd9, 1, 1, 1, 1, 16'hA5A5, 4'd0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      auth(4'd9, 16'h0001, 0);
      check("nadm_cnt", 32'(bus.my_count_out), 32'(i + 1));
      check("nadm_lk",  32'(bus.my_auth_locked), (i == 2) ? 32'h1 : 32'h0);
    end
    check("nadm_lockout", 32'(bus.my_lock_out), 32'h1);
    auth(4'd9, 16'hA5A5, 0);
    check("lockd_ok",  32'(bus.my_auth_ok), 32'h0);
    check("lockd_lk",  32'(bus.my_auth_locked), 32'h1);
    check("lockd_cnt", 32'(bus.my_count_out), 32'h3);

    direct(4'd3, 1, 1, 1, 1, 16'h7777, 4'd0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      auth(4'd3, 16'h1111, 0);
      check("adm_cnt", 32'(bus.my_count_out), 32'(cseq[i]));
      check("adm_lk",  32'(bus.my_auth_locked), 32'h0);
    end
    check("adm_lockout", 32'(bus.my_lock_out), 32'h0);
    auth(4'd3, 16'h7777, 0);
    check("adm_ok", 32'(bus.my_auth_ok), 32'h1);
    check("adm_c0", 32'(bus.my_count_out), 32'h0);

    rd(4'd3);
    d0 = n_done;
    auth(4'd3, 16'h7777, 1);
    rd(4'd3);
    check("busy_pass", 32'(bus.my_pass_out), 32'h7777);
    rd(4'd3);
    check("busy_done", 32'(n_done - d0), 32'h1);

    d0 = n_done;
    bus.my_cs = 1'b1; bus.my_auth_start = 1'b1; bus.my_addr = 4'd5; bus.my_pass_in = 16'h0BAD;
    @(posedge clk); #1;
    idle_inputs();
    exp_ready = 1'b0; exp_done = 1'b0;
    @(posedge clk); #1;
    do_reset();
    rd(4'd5);
    check("rst_cmp_pass", 32'(bus.my_pass_out), 32'h0);
    check("rst_cmp_cnt",  32'(bus.my_count_out), 32'h0);
    check("rst_cmp_done", 32'(n_done - d0), 32'h0);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
